png_line_ctrl: RTL and testbench

- Sequences the single-port, register-based line buffer used by the PNG filter stage.
- Accepts a raster pixel stream and, for each pixel, issues a read of the previous-row byte and then a write of the current byte. Reads and writes are never issued in the same cycle.
- Presents the cur/up/left/upleft neighbourhood to the filter unit.
- Owns the row and column counters that keep the buffer's internal wrap pointers aligned.

---
 rtl/png_line_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_png_line_ctrl.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/png_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : png_line_ctrl
// Desc     : Line-buffer sequencer for the PNG filter stage. Accepts a raster
//            pixel stream, reads the previous-row byte from a single-port
//            line buffer, writes the current byte back, and presents the
//            cur/up/left/upleft neighbourhood to the filter unit.
// Options  : PNG_LAST_ROW_SKIP_WR_EN - when defined, the last row of a frame
//            issues no buffer writes (the row is skipped in full, so the
//            buffer's wrap pointers stay aligned).
// Revision : 1.0 - initial release
// ============================================================================
module png_line_ctrl #(
    parameter int DATA_WD = 8,
    parameter int W_WD    = 13,
    parameter int H_WD    = 13
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [W_WD-1:0]    cfg_w_i,
    input  logic [H_WD-1:0]    cfg_h_i,
    input  logic               pix_val_i,
    input  logic [DATA_WD-1:0] pix_dat_i,
    output logic               pix_rdy_o,
    output logic               buf_wr_val_o,
    output logic [DATA_WD-1:0] buf_wr_dat_o,
    output logic               buf_rd_val_o,
    input  logic [DATA_WD-1:0] buf_rd_dat_i,
    output logic               flt_val_o,
    output logic [DATA_WD-1:0] flt_cur_o,
    output logic [DATA_WD-1:0] flt_up_o,
    output logic [DATA_WD-1:0] flt_left_o,
    output logic [DATA_WD-1:0] flt_upleft_o,
    output logic               flt_sol_o,
    output logic               flt_eol_o,
    output logic               flt_eof_o,
    output logic               busy_o,
    output logic               done_o
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACPT = 2'd1;
    localparam logic [1:0] S_RD   = 2'd2;
    localparam logic [1:0] S_WR   = 2'd3;

    localparam logic [W_WD-1:0] C_W_ONE = W_WD'(1);
    localparam logic [H_WD-1:0] C_H_ONE = H_WD'(1);

    // ------------------------------------------------------------------
    // Registers and next-state values
    // ------------------------------------------------------------------
    logic [1:0]         state_q,      state_d;
    logic [W_WD-1:0]    cfg_w_q,      cfg_w_d;
    logic [H_WD-1:0]    cfg_h_q,      cfg_h_d;
    logic [W_WD-1:0]    x_q,          x_d;
    logic [H_WD-1:0]    y_q,          y_d;
    logic [DATA_WD-1:0] cur_q,        cur_d;
    logic               flt_val_q,    flt_val_d;
    logic [DATA_WD-1:0] flt_cur_q,    flt_cur_d;
    logic [DATA_WD-1:0] flt_up_q,     flt_up_d;
    logic [DATA_WD-1:0] flt_left_q,   flt_left_d;
    logic [DATA_WD-1:0] flt_upleft_q, flt_upleft_d;
    logic               flt_sol_q,    flt_sol_d;
    logic               flt_eol_q,    flt_eol_d;
    logic               flt_eof_q,    flt_eof_d;
    logic               done_q,       done_d;

    // ------------------------------------------------------------------
    // Position decode for the pixel currently in flight
    // ------------------------------------------------------------------
    logic w_cfg_zero;
    logic w_first_col;
    logic w_first_row;
    logic w_last_col;
    logic w_last_row;
    logic w_eof;

    assign w_cfg_zero  = (cfg_w_i == '0) || (cfg_h_i == '0);
    assign w_first_col = (x_q == '0);
    assign w_first_row = (y_q == '0);
    assign w_last_col  = (x_q == (cfg_w_q - C_W_ONE));
    assign w_last_row  = (y_q == (cfg_h_q - C_H_ONE));
    assign w_eof       = w_last_col && w_last_row;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: row 0 has nothing above it, so it skips the read
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && !w_cfg_zero) begin
                    state_d = S_ACPT;
                end
            end
            S_ACPT: begin
                if (pix_val_i) begin
                    state_d = w_first_row ? S_WR : S_RD;
                end
            end
            S_RD: begin
                state_d = S_WR;
            end
            S_WR: begin
                state_d = w_eof ? S_IDLE : S_ACPT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode: strobes are one-hot per state so read and write never overlap
    always_comb begin
        pix_rdy_o    = 1'b0;
        buf_rd_val_o = 1'b0;
        buf_wr_val_o = 1'b0;
        busy_o       = (state_q != S_IDLE);
        case (state_q)
            S_ACPT: pix_rdy_o    = 1'b1;
            S_RD:   buf_rd_val_o = 1'b1;
`ifdef PNG_LAST_ROW_SKIP_WR_EN
            // Nothing reads the last row back, so its write is dropped.
            S_WR:   buf_wr_val_o = !w_last_row;
`else
            S_WR:   buf_wr_val_o = 1'b1;
`endif
            default: begin
                pix_rdy_o    = 1'b0;
            end
        endcase
    end

    // Datapath next-state: config latch, pixel capture, neighbourhood and counters
    always_comb begin
        cfg_w_d      = cfg_w_q;
        cfg_h_d      = cfg_h_q;
        x_d          = x_q;
        y_d          = y_q;
        cur_d        = cur_q;
        flt_val_d    = 1'b0;
        flt_cur_d    = flt_cur_q;
        flt_up_d     = flt_up_q;
        flt_left_d   = flt_left_q;
        flt_upleft_d = flt_upleft_q;
        flt_sol_d    = flt_sol_q;
        flt_eol_d    = flt_eol_q;
        flt_eof_d    = flt_eof_q;
        done_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (w_cfg_zero) begin
                        // Empty frame completes immediately.
                        done_d = 1'b1;
                    end else begin
                        cfg_w_d = cfg_w_i;
                        cfg_h_d = cfg_h_i;
                        x_d     = '0;
                        y_d     = '0;
                    end
                end
            end
            S_ACPT: begin
                if (pix_val_i) begin
                    cur_d = pix_dat_i;
                end
            end
            S_WR: begin
                flt_val_d    = 1'b1;
                flt_cur_d    = cur_q;
                // Read data is only meaningful if this pixel went through RD.
                flt_up_d     = w_first_row ? '0 : buf_rd_dat_i;
                // The previous neighbourhood still sits in the output
                // registers, so its cur/up become this pixel's left/upleft.
                flt_left_d   = w_first_col ? '0 : flt_cur_q;
                flt_upleft_d = (w_first_col || w_first_row) ? '0 : flt_up_q;
                flt_sol_d    = w_first_col;
                flt_eol_d    = w_last_col;
                flt_eof_d    = w_eof;
                if (w_last_col) begin
                    x_d = '0;
                    y_d = y_q + C_H_ONE;
                end else begin
                    x_d = x_q + C_W_ONE;
                end
                if (w_eof) begin
                    done_d = 1'b1;
                end
            end
            default: begin
                cur_d = cur_q;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_w_q      <= '0;
            cfg_h_q      <= '0;
            x_q          <= '0;
            y_q          <= '0;
            cur_q        <= '0;
            flt_val_q    <= 1'b0;
            flt_cur_q    <= '0;
            flt_up_q     <= '0;
            flt_left_q   <= '0;
            flt_upleft_q <= '0;
            flt_sol_q    <= 1'b0;
            flt_eol_q    <= 1'b0;
            flt_eof_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            cfg_w_q      <= cfg_w_d;
            cfg_h_q      <= cfg_h_d;
            x_q          <= x_d;
            y_q          <= y_d;
            cur_q        <= cur_d;
            flt_val_q    <= flt_val_d;
            flt_cur_q    <= flt_cur_d;
            flt_up_q     <= flt_up_d;
            flt_left_q   <= flt_left_d;
            flt_upleft_q <= flt_upleft_d;
            flt_sol_q    <= flt_sol_d;
            flt_eol_q    <= flt_eol_d;
            flt_eof_q    <= flt_eof_d;
            done_q       <= done_d;
        end
    end

    assign buf_wr_dat_o = cur_q;
    assign flt_val_o    = flt_val_q;
    assign flt_cur_o    = flt_cur_q;
    assign flt_up_o     = flt_up_q;
    assign flt_left_o   = flt_left_q;
    assign flt_upleft_o = flt_upleft_q;
    assign flt_sol_o    = flt_sol_q;
    assign flt_eol_o    = flt_eol_q;
    assign flt_eof_o    = flt_eof_q;
    assign done_o       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_png_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_png_line_ctrl
// Desc     : Self-checking bench for png_line_ctrl with a behavioural line
//            buffer and a raster-index neighbourhood reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_png_line_ctrl;

    localparam int DW = 8;
    localparam int WW = 13;
    localparam int HW = 13;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [WW-1:0] cfg_w = '0;
    logic [HW-1:0] cfg_h = '0;
    logic          pix_val = 1'b0;
    logic [DW-1:0] pix_dat = '0;
    logic          pix_rdy_o, buf_wr_val_o, buf_rd_val_o;
    logic [DW-1:0] buf_wr_dat_o, buf_rd_dat;
    logic          flt_val_o, flt_sol_o, flt_eol_o, flt_eof_o, busy_o, done_o;
    logic [DW-1:0] flt_cur_o, flt_up_o, flt_left_o, flt_upleft_o;

    png_line_ctrl #(.DATA_WD(DW), .W_WD(WW), .H_WD(HW)) dut (
        .clk(clk), .rst(rst), .start_i(start), .cfg_w_i(cfg_w), .cfg_h_i(cfg_h),
        .pix_val_i(pix_val), .pix_dat_i(pix_dat), .pix_rdy_o(pix_rdy_o),
        .buf_wr_val_o(buf_wr_val_o), .buf_wr_dat_o(buf_wr_dat_o),
        .buf_rd_val_o(buf_rd_val_o), .buf_rd_dat_i(buf_rd_dat),
        .flt_val_o(flt_val_o), .flt_cur_o(flt_cur_o), .flt_up_o(flt_up_o),
        .flt_left_o(flt_left_o), .flt_upleft_o(flt_upleft_o),
        .flt_sol_o(flt_sol_o), .flt_eol_o(flt_eol_o), .flt_eof_o(flt_eof_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    wire [34:0] fltv = {flt_cur_o, flt_up_o, flt_left_o, flt_upleft_o,
                        flt_sol_o, flt_eol_o, flt_eof_o};
    wire [48:0] all_outs = {pix_rdy_o, buf_wr_val_o, buf_wr_dat_o, buf_rd_val_o,
                            flt_val_o, fltv, busy_o, done_o};

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Behavioural single-port line buffer: wrap pointers at the row width.
    logic [DW-1:0] bmem [0:63];
    int bw = 1;
    int bwp = 0;
    int brp = 0;
    always @(posedge clk) begin
        if (rst) begin
            bwp <= 0;
            brp <= 0;
            buf_rd_dat <= '0;
        end else begin
            if (buf_wr_val_o) begin
                bmem[bwp] <= buf_wr_dat_o;
                bwp <= (bwp >= bw - 1) ? 0 : bwp + 1;
            end
            if (buf_rd_val_o) begin
                buf_rd_dat <= bmem[brp];
                brp <= (brp >= bw - 1) ? 0 : brp + 1;
            end
        end
    end

    // Monitor: counters only grow, tests take snapshots.
    logic [34:0] cap_vec [$];
    int          cap_cyc [$];
    logic [7:0]  wr_q [$];
    int rd_cnt = 0, both_cnt = 0, done_cnt = 0, done_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (flt_val_o) begin
            cap_vec.push_back(fltv);
            cap_cyc.push_back(cyc);
        end
        if (buf_wr_val_o) wr_q.push_back(buf_wr_dat_o);
        if (buf_rd_val_o) rd_cnt <= rd_cnt + 1;
        if (buf_rd_val_o && buf_wr_val_o) both_cnt <= both_cnt + 1;
        if (done_o) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    logic [7:0] pix [0:63];
    int cap_base, wr_base, rd_base, both_base, done_base;
    int stall_act, stall_chg;
    logic [34:0] stall_save;
    logic [48:0] abort_outs;

    // Reference neighbourhood from raster position.
    function automatic logic [34:0] exp_vec(input int i, input int w, input int h);
        int x = i % w;
        int y = i / w;
        logic [7:0] up = (y > 0) ? pix[i - w] : 8'd0;
        logic [7:0] lf = (x > 0) ? pix[i - 1] : 8'd0;
        logic [7:0] ul = (x > 0 && y > 0) ? pix[i - w - 1] : 8'd0;
        logic eol = (x == w - 1);
        logic eof = eol && (y == h - 1);
        return {pix[i], up, lf, ul, (x == 0), eol, eof};
    endfunction

    function automatic int exp_writes(input int w, input int h);
`ifdef PNG_LAST_ROW_SKIP_WR_EN
        return w * (h - 1);
`else
        return w * h;
`endif
    endfunction

    // Drive one frame; stall/poke/abort select optional disturbances (-1 = none).
    task automatic run_frame(input int w, input int h, input int stall_at,
                             input int poke_at, input int abort_at, output bit ok);
        int n;
        ok = 1'b1;
        bw = w;
        stall_act = 0;
        stall_chg = 0;
        cap_base = cap_vec.size();
        wr_base = wr_q.size();
        rd_base = rd_cnt;
        both_base = both_cnt;
        done_base = done_cnt;
        pix_val = 1'b1;
        pix_dat = pix[0];
        cfg_w = WW'(w);
        cfg_h = HW'(h);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < w * h; i++) begin
            if (i == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                abort_outs = all_outs;
                rst = 1'b0;
                pix_val = 1'b0;
                return;
            end
            pix_dat = pix[i];
            n = 0;
            while (!pix_rdy_o && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            if (!pix_rdy_o) begin
                ok = 1'b0;
                pix_val = 1'b0;
                return;
            end
            if (i == stall_at) begin
                stall_save = fltv;
                pix_val = 1'b0;
                repeat (5) begin
                    @(posedge clk); #1;
                    if (buf_rd_val_o || buf_wr_val_o || flt_val_o) stall_act++;
                    if (fltv !== stall_save) stall_chg++;
                end
                pix_val = 1'b1;
            end
            @(posedge clk); #1;
            if (i == poke_at) begin
                cfg_w = WW'(2);
                cfg_h = HW'(1);
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                cfg_w = WW'(w);
                cfg_h = HW'(h);
            end
        end
        pix_val = 1'b0;
        n = 0;
        while (done_cnt == done_base && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (done_cnt == done_base) ok = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (all_outs !== '0) $display("FAIL reset_hold: got %h expected 0", all_outs);
        if (all_outs !== '0) errors++;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (all_outs !== '0) begin
            errors++;
            $display("FAIL reset_idle: got %h expected 0", all_outs);
        end
    endtask

    task automatic test_frames();
        int w, h, ngot, nw, d;
        bit ok;
        for (int f = 0; f < 5; f++) begin
            if (f == 0) begin
                w = 4; h = 3;
                for (int k = 0; k < 12; k++) pix[k] = 8'(k + 1);
            end else if (f == 1) begin
                w = 1; h = 2;
                pix[0] = 8'd9; pix[1] = 8'd7;
            end else begin
                w = $urandom_range(1, 6);
                h = $urandom_range(1, 4);
                for (int k = 0; k < w * h; k++) pix[k] = 8'($urandom);
            end
            run_frame(w, h, -1, -1, -1, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL frame_timeout: got 0 expected 1 (frame %0d)", f); end
            ngot = cap_vec.size() - cap_base;
            checks++;
            if (ngot != w * h) begin errors++; $display("FAIL flt_count: got %0d expected %0d", ngot, w * h); end
            for (int i = 0; i < w * h && i < ngot; i++) begin
                checks++;
                if (cap_vec[cap_base + i] !== exp_vec(i, w, h)) begin
                    errors++;
                    $display("FAIL neighbourhood f%0d p%0d: got %h expected %h",
                             f, i, cap_vec[cap_base + i], exp_vec(i, w, h));
                end
            end
            for (int i = 1; i < w * h && i < ngot; i++) begin
                d = cap_cyc[cap_base + i] - cap_cyc[cap_base + i - 1];
                checks++;
                if (d != ((i / w == 0) ? 2 : 3)) begin
                    errors++;
                    $display("FAIL pixel_interval f%0d p%0d: got %0d expected %0d",
                             f, i, d, (i / w == 0) ? 2 : 3);
                end
            end
            if (ngot > 0) begin
                checks++;
                if (done_cyc != cap_cyc[cap_vec.size() - 1] || done_cnt - done_base != 1) begin
                    errors++;
                    $display("FAIL done_align: got cyc %0d cnt %0d expected cyc %0d cnt 1",
                             done_cyc, done_cnt - done_base, cap_cyc[cap_vec.size() - 1]);
                end
            end
            checks++;
            if (rd_cnt - rd_base != w * (h - 1)) begin
                errors++;
                $display("FAIL read_count: got %0d expected %0d", rd_cnt - rd_base, w * (h - 1));
            end
            checks++;
            if (both_cnt != both_base) begin
                errors++;
                $display("FAIL strobe_overlap: got %0d expected 0", both_cnt - both_base);
            end
            nw = wr_q.size() - wr_base;
            checks++;
            if (nw != exp_writes(w, h)) begin
                errors++;
                $display("FAIL write_count: got %0d expected %0d", nw, exp_writes(w, h));
            end
            for (int i = 0; i < nw && i < exp_writes(w, h); i++) begin
                checks++;
                if (wr_q[wr_base + i] !== pix[i]) begin
                    errors++;
                    $display("FAIL write_data p%0d: got %h expected %h", i, wr_q[wr_base + i], pix[i]);
                end
            end
            checks++;
            if (busy_o !== 1'b0) begin errors++; $display("FAIL busy_after: got %b expected 0", busy_o); end
        end
    endtask

    task automatic test_stall();
        bit ok;
        int ngot;
        for (int k = 0; k < 12; k++) pix[k] = 8'($urandom);
        run_frame(4, 3, 5, -1, -1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stall_timeout: got 0 expected 1"); end
        checks++;
        if (stall_act != 0) begin errors++; $display("FAIL stall_activity: got %0d expected 0", stall_act); end
        checks++;
        if (stall_chg != 0) begin errors++; $display("FAIL stall_hold: got %0d expected 0", stall_chg); end
        ngot = cap_vec.size() - cap_base;
        checks++;
        if (ngot != 12) begin errors++; $display("FAIL stall_count: got %0d expected 12", ngot); end
        for (int i = 0; i < 12 && i < ngot; i++) begin
            checks++;
            if (cap_vec[cap_base + i] !== exp_vec(i, 4, 3)) begin
                errors++;
                $display("FAIL stall_neighbourhood p%0d: got %h expected %h",
                         i, cap_vec[cap_base + i], exp_vec(i, 4, 3));
            end
        end
        checks++;
        if (rd_cnt - rd_base != 8) begin errors++; $display("FAIL stall_reads: got %0d expected 8", rd_cnt - rd_base); end
    endtask

    task automatic test_start_ignore();
        bit ok;
        int ngot, cb, wb, rb;
        for (int k = 0; k < 12; k++) pix[k] = 8'($urandom);
        run_frame(4, 3, -1, 2, -1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL poke_timeout: got 0 expected 1"); end
        ngot = cap_vec.size() - cap_base;
        checks++;
        if (ngot != 12 || done_cnt - done_base != 1) begin
            errors++;
            $display("FAIL poke_count: got %0d/%0d expected 12/1", ngot, done_cnt - done_base);
        end
        for (int i = 0; i < 12 && i < ngot; i++) begin
            checks++;
            if (cap_vec[cap_base + i] !== exp_vec(i, 4, 3)) begin
                errors++;
                $display("FAIL poke_neighbourhood p%0d: got %h expected %h",
                         i, cap_vec[cap_base + i], exp_vec(i, 4, 3));
            end
        end
        cb = cap_vec.size(); wb = wr_q.size(); rb = rd_cnt;
        cfg_w = WW'(4); cfg_h = HW'(0); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL empty_done: got done=%b busy=%b expected done=1 busy=0", done_o, busy_o);
        end
        @(posedge clk); #1;
        checks++;
        if (done_o !== 1'b0) begin errors++; $display("FAIL empty_pulse: got %b expected 0", done_o); end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (cap_vec.size() != cb || wr_q.size() != wb || rd_cnt != rb || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL empty_strobes: got flt=%0d wr=%0d rd=%0d busy=%b expected 0 0 0 0",
                     cap_vec.size() - cb, wr_q.size() - wb, rd_cnt - rb, busy_o);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int ngot, db;
        for (int k = 0; k < 12; k++) pix[k] = 8'($urandom);
        run_frame(4, 3, -1, -1, 6, ok);
        db = done_base;
        checks++;
        if (abort_outs !== '0) begin errors++; $display("FAIL abort_outputs: got %h expected 0", abort_outs); end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != db) begin errors++; $display("FAIL abort_done: got %0d expected 0", done_cnt - db); end
        for (int k = 0; k < 8; k++) pix[k] = 8'(k + 1);
        run_frame(4, 2, -1, -1, -1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL after_abort_timeout: got 0 expected 1"); end
        ngot = cap_vec.size() - cap_base;
        checks++;
        if (ngot != 8) begin errors++; $display("FAIL after_abort_count: got %0d expected 8", ngot); end
        for (int i = 0; i < 8 && i < ngot; i++) begin
            checks++;
            if (cap_vec[cap_base + i] !== exp_vec(i, 4, 2)) begin
                errors++;
                $display("FAIL after_abort_neighbourhood p%0d: got %h expected %h",
                         i, cap_vec[cap_base + i], exp_vec(i, 4, 2));
            end
        end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_stall();
        test_start_ignore();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
